// File: rtl/ocx_req_tracker_pkg.sv
// Shared constants, types and the lowest-set-bit encoder for the OpenCAPI request tracker.
package ocx_trk_pkg;

  localparam int NSTRMS  = 64;
  localparam int NTAGS   = 32;
  localparam int MAX_OUT = 8;

  typedef logic [$clog2(NSTRMS)-1:0] sid_t;
  typedef logic [$clog2(NTAGS)-1:0]  tag_t;

  // Encoder accepts bitmaps up to ENC_W wide; narrower maps are zero-extended by the caller.
  localparam int unsigned ENC_W  = 256;
  localparam int unsigned ENC_AW = 8;

  function automatic int unsigned lowest_set(input logic [ENC_W-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = ENC_W; i > 0; i--) begin
      if (v[ENC_AW'(i - 1)]) idx = i - 1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ocx_req_tracker_if.sv
// Request/command/host-response/response handshakes of the tracker; slave is the tracker side.
interface ocx_req_tracker_if
  import ocx_trk_pkg::*;
#(
  parameter int sid_width = $clog2(NSTRMS),
  parameter int tag_width = $clog2(NTAGS)
);
  logic                 i_req_v;
  logic                 i_req_r;
  logic [sid_width-1:0] i_req_sid;
  logic                 o_cmd_v;
  logic                 o_cmd_r;
  logic [tag_width-1:0] o_cmd_tag;
  logic [sid_width-1:0] o_cmd_sid;
  logic                 i_hrsp_v;
  logic                 i_hrsp_r;
  logic [tag_width-1:0] i_hrsp_tag;
  logic                 o_rsp_v;
  logic                 o_rsp_r;
  logic [sid_width-1:0] o_rsp_sid;

  modport slave (
    input  i_req_v, i_req_sid, o_cmd_r, i_hrsp_v, i_hrsp_tag, o_rsp_r,
    output i_req_r, o_cmd_v, o_cmd_tag, o_cmd_sid, i_hrsp_r, o_rsp_v, o_rsp_sid
  );

  modport master (
    output i_req_v, i_req_sid, o_cmd_r, i_hrsp_v, i_hrsp_tag, o_rsp_r,
    input  i_req_r, o_cmd_v, o_cmd_tag, o_cmd_sid, i_hrsp_r, o_rsp_v, o_rsp_sid
  );
endinterface

// File: rtl/base_areg.sv
// Single-entry valid/ready register slice; accepts whenever empty or being drained.
module base_areg #(
  parameter int width = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_v,
  output logic             i_r,
  input  logic [width-1:0] i_d,
  output logic             o_v,
  input  logic             o_r,
  output logic [width-1:0] o_d
);

  assign i_r = ~o_v | o_r;

  always_ff @(posedge clk) begin
    if (!reset) begin
      o_v <= 1'b0;
      o_d <= '0;
    end else begin
      if (i_r) o_v <= i_v;
      if (i_v && i_r) o_d <= i_d;
    end
  end

endmodule

// File: rtl/ocx_req_tracker_alloc.sv
// Host tag allocator: free bitmap with lowest-free-first allocation and a busy query port.
module ocx_tag_alloc
  import ocx_trk_pkg::*;
#(
  parameter int ntags     = NTAGS,
  parameter int tag_width = $clog2(ntags)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_v,
  output logic                 alloc_ok,
  output logic [tag_width-1:0] alloc_tag,
  input  logic                 free_v,
  input  logic [tag_width-1:0] free_tag,
  input  logic [tag_width-1:0] query_tag,
  output logic                 query_busy,
  output logic                 all_free
);

  logic [ntags-1:0] free_map;
  logic [ntags-1:0] alloc_mask;
  logic [ntags-1:0] free_mask;

  assign alloc_ok   = |free_map;
  assign alloc_tag  = tag_width'(lowest_set(ENC_W'(free_map)));
  assign query_busy = ~free_map[query_tag];
  assign all_free   = &free_map;

  assign alloc_mask = alloc_v ? (ntags'(1) << alloc_tag) : '0;
  assign free_mask  = free_v  ? (ntags'(1) << free_tag)  : '0;

  // A tag freed this cycle only becomes allocatable next cycle.
  always_ff @(posedge clk) begin
    if (!reset) free_map <= '1;
    else        free_map <= (free_map & ~alloc_mask) | free_mask;
  end

endmodule

// File: rtl/ocx_req_tracker.sv
// OpenCAPI request tracker: tags stream-buffer requests, matches out-of-order host responses.
// Optional perf counters built only when OCX_REQ_TRACKER_PERF_EN is defined.
module ocx_req_tracker
  import ocx_trk_pkg::*;
#(
  parameter int nstrms    = NSTRMS,
  parameter int sid_width = $clog2(nstrms),
  parameter int ntags     = NTAGS,
  parameter int tag_width = $clog2(ntags),
  parameter int max_out   = MAX_OUT,
  parameter int cnt_width = $clog2(max_out + 1)
) (
  input  logic               clk,
  input  logic               reset,
  ocx_req_tracker_if.slave   bus,
  output logic               o_err,
  output logic               o_idle,
  output logic [31:0]        o_perf_req,
  output logic [31:0]        o_perf_stall
);

  logic [cnt_width-1:0] cnt [nstrms];
  logic [sid_width-1:0] tag_sid [ntags];

  logic                 alloc_ok, all_free, hrsp_busy;
  logic [tag_width-1:0] alloc_tag;
  logic                 cmd_in_r, cnt_ok, req_acc, rsp_acc;
  logic [sid_width-1:0] rsp_sid_rd;
  logic [tag_width+sid_width-1:0] cmd_q;

  assign cnt_ok      = cnt[bus.i_req_sid] < cnt_width'(max_out);
  assign bus.i_req_r = cmd_in_r & alloc_ok & cnt_ok;
  assign req_acc     = bus.i_req_v & bus.i_req_r;
  assign rsp_acc     = bus.i_hrsp_v & bus.i_hrsp_r & hrsp_busy;
  assign rsp_sid_rd  = tag_sid[bus.i_hrsp_tag];

  ocx_tag_alloc #(.ntags(ntags), .tag_width(tag_width)) u_alloc (
    .clk        (clk),
    .reset      (reset),
    .alloc_v    (req_acc),
    .alloc_ok   (alloc_ok),
    .alloc_tag  (alloc_tag),
    .free_v     (rsp_acc),
    .free_tag   (bus.i_hrsp_tag),
    .query_tag  (bus.i_hrsp_tag),
    .query_busy (hrsp_busy),
    .all_free   (all_free)
  );

  base_areg #(.width(tag_width + sid_width)) u_cmd (
    .clk   (clk),
    .reset (reset),
    .i_v   (req_acc),
    .i_r   (cmd_in_r),
    .i_d   ({alloc_tag, bus.i_req_sid}),
    .o_v   (bus.o_cmd_v),
    .o_r   (bus.o_cmd_r),
    .o_d   (cmd_q)
  );
  assign {bus.o_cmd_tag, bus.o_cmd_sid} = cmd_q;

  // Unallocated tags are still accepted (and dropped), so ready ignores tag state.
  base_areg #(.width(sid_width)) u_rsp (
    .clk   (clk),
    .reset (reset),
    .i_v   (bus.i_hrsp_v & hrsp_busy),
    .i_r   (bus.i_hrsp_r),
    .i_d   (rsp_sid_rd),
    .o_v   (bus.o_rsp_v),
    .o_r   (bus.o_rsp_r),
    .o_d   (bus.o_rsp_sid)
  );

  always_ff @(posedge clk) begin
    if (req_acc) tag_sid[alloc_tag] <= bus.i_req_sid;
  end

  // Same-sid request and response in one cycle cancel out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < nstrms; i++) cnt[i] <= '0;
    end else begin
      if (req_acc && !(rsp_acc && rsp_sid_rd == bus.i_req_sid))
        cnt[bus.i_req_sid] <= cnt[bus.i_req_sid] + cnt_width'(1);
      if (rsp_acc && !(req_acc && rsp_sid_rd == bus.i_req_sid))
        cnt[rsp_sid_rd] <= cnt[rsp_sid_rd] - cnt_width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)                                          o_err <= 1'b0;
    else if (bus.i_hrsp_v && bus.i_hrsp_r && !hrsp_busy) o_err <= 1'b1;
  end

  assign o_idle = all_free & ~bus.o_cmd_v & ~bus.o_rsp_v;

  a_cnt_no_underflow: assert property (@(posedge clk) disable iff (!reset)
    rsp_acc |-> cnt[rsp_sid_rd] != '0);

`ifdef OCX_REQ_TRACKER_PERF_EN
  logic [31:0] perf_req_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_req_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (bus.o_cmd_v && bus.o_cmd_r && perf_req_q != '1)   perf_req_q   <= perf_req_q + 32'd1;
      if (bus.i_req_v && !bus.i_req_r && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign o_perf_req   = perf_req_q;
  assign o_perf_stall = perf_stall_q;
`else
  assign o_perf_req   = '0;
  assign o_perf_stall = '0;
`endif

endmodule

// File: tb/tb_ocx_req_tracker.sv
// Bench for ocx_req_tracker: vector table, directed corner sequences, random run vs. a tag-pool model.
module tb_ocx_req_tracker;
  import ocx_trk_pkg::*;

  localparam int NS = 64;
  localparam int NT = 32;
  localparam int MO = 8;
  localparam int SW = $clog2(NS);
  localparam int TW = $clog2(NT);
`ifdef OCX_REQ_TRACKER_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        o_err, o_idle;
  logic [31:0] o_perf_req, o_perf_stall;

  ocx_req_tracker_if #(.sid_width(SW), .tag_width(TW)) bus ();

  ocx_req_tracker #(.nstrms(NS), .ntags(NT), .max_out(MO)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .o_err        (o_err),
    .o_idle       (o_idle),
    .o_perf_req   (o_perf_req),
    .o_perf_stall (o_perf_stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pool of busy tags with owning sid, per-sid outstanding counts, two output slots.
  bit      m_ok = 1'b0;
  bit      m_busy [NT];
  int      m_tsid [NT];
  int      m_cnt  [NS];
  bit      m_cmd_v, m_rsp_v, m_err;
  int      m_cmd_tag, m_cmd_sid, m_rsp_sid;
  longint  m_preq, m_pstall;

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    foreach (m_cnt[i])  m_cnt[i]  = 0;
    m_cmd_v = 0; m_rsp_v = 0; m_err = 0;
    m_preq = 0; m_pstall = 0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      model_reset();
      m_ok = 1'b1;
    end else if (m_ok) begin
      int  lf, sid, tag, nbusy;
      bit  req_r, hrsp_r;
      lf = -1; nbusy = 0;
      for (int i = NT - 1; i >= 0; i--) begin
        if (!m_busy[i]) lf = i;
        else nbusy++;
      end
      sid = int'(bus.i_req_sid);
      tag = int'(bus.i_hrsp_tag);
      req_r  = (!m_cmd_v || bus.o_cmd_r) && lf >= 0 && m_cnt[sid] < MO;
      hrsp_r = !m_rsp_v || bus.o_rsp_r;

      chk("m_cmd_v", bus.o_cmd_v, m_cmd_v);
      if (m_cmd_v) begin
        chk("m_cmd_tag", bus.o_cmd_tag, m_cmd_tag);
        chk("m_cmd_sid", bus.o_cmd_sid, m_cmd_sid);
      end
      chk("m_rsp_v", bus.o_rsp_v, m_rsp_v);
      if (m_rsp_v) chk("m_rsp_sid", bus.o_rsp_sid, m_rsp_sid);
      chk("m_err", o_err, m_err);
      chk("m_idle", o_idle, nbusy == 0 && !m_cmd_v && !m_rsp_v);
      chk("m_req_r", bus.i_req_r, req_r);
      chk("m_hrsp_r", bus.i_hrsp_r, hrsp_r);
      chk("m_perf_req", o_perf_req, PERF ? m_preq : 0);
      chk("m_perf_stall", o_perf_stall, PERF ? m_pstall : 0);

      if (m_cmd_v && bus.o_cmd_r && m_preq < 64'hffff_ffff) m_preq++;
      if (bus.i_req_v && !req_r && m_pstall < 64'hffff_ffff) m_pstall++;

      if (m_rsp_v && bus.o_rsp_r) m_rsp_v = 0;
      if (bus.i_hrsp_v && hrsp_r) begin
        if (m_busy[tag]) begin
          m_rsp_v = 1; m_rsp_sid = m_tsid[tag];
          m_busy[tag] = 0; m_cnt[m_tsid[tag]]--;
        end else m_err = 1;
      end

      if (m_cmd_v && bus.o_cmd_r) m_cmd_v = 0;
      if (bus.i_req_v && req_r) begin
        m_cmd_v = 1; m_cmd_tag = lf; m_cmd_sid = sid;
        m_busy[lf] = 1; m_tsid[lf] = sid; m_cnt[sid]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.i_req_v = 0; bus.i_req_sid = '0; bus.o_cmd_r = 1;
    bus.i_hrsp_v = 0; bus.i_hrsp_tag = '0; bus.o_rsp_r = 1;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 0;
    tick(); tick();
    reset = 1;
    chk("rst_cmd_v", bus.o_cmd_v, 0);
    chk("rst_rsp_v", bus.o_rsp_v, 0);
    chk("rst_err", o_err, 0);
    chk("rst_idle", o_idle, 1);
    chk("rst_perf_req", o_perf_req, 0);
    chk("rst_perf_stall", o_perf_stall, 0);
  endtask

  task automatic req(input int sid);
    bus.i_req_v = 1; bus.i_req_sid = SW'(sid);
  endtask

  typedef struct {
    bit req_v; int sid; bit cmd_r; bit hrsp_v; int tag; bit rsp_r;
    bit e_req_r; bit e_cmd_v; int e_cmd_tag; int e_cmd_sid;
    bit e_rsp_v; int e_rsp_sid; bit e_idle; bit e_err;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{1, 5, 1, 0, 0, 1,  1, 1, 0, 5,  0, 0, 0, 0};
    vecs[1] = '{0, 5, 1, 0, 0, 1,  1, 0, 0, 0,  0, 0, 0, 0};
    vecs[2] = '{0, 5, 1, 1, 0, 1,  1, 0, 0, 0,  1, 5, 0, 0};
    vecs[3] = '{0, 5, 1, 0, 0, 1,  1, 0, 0, 0,  0, 0, 1, 0};
    vecs[4] = '{0, 5, 1, 1, 9, 1,  1, 0, 0, 0,  0, 0, 1, 1};
    vecs[5] = '{0, 5, 1, 0, 0, 1,  1, 0, 0, 0,  0, 0, 1, 1};

    set_idle();
    do_reset();

    // Single round trip, then an unallocated-tag response.
    foreach (vecs[k]) begin
      bus.i_req_v = vecs[k].req_v; bus.i_req_sid = SW'(vecs[k].sid);
      bus.o_cmd_r = vecs[k].cmd_r; bus.i_hrsp_v = vecs[k].hrsp_v;
      bus.i_hrsp_tag = TW'(vecs[k].tag); bus.o_rsp_r = vecs[k].rsp_r;
      #1 chk($sformatf("v%0d_req_r", k), bus.i_req_r, vecs[k].e_req_r);
      tick();
      chk($sformatf("v%0d_cmd_v", k), bus.o_cmd_v, vecs[k].e_cmd_v);
      if (vecs[k].e_cmd_v) begin
        chk($sformatf("v%0d_cmd_tag", k), bus.o_cmd_tag, vecs[k].e_cmd_tag);
        chk($sformatf("v%0d_cmd_sid", k), bus.o_cmd_sid, vecs[k].e_cmd_sid);
      end
      chk($sformatf("v%0d_rsp_v", k), bus.o_rsp_v, vecs[k].e_rsp_v);
      if (vecs[k].e_rsp_v) chk($sformatf("v%0d_rsp_sid", k), bus.o_rsp_sid, vecs[k].e_rsp_sid);
      chk($sformatf("v%0d_idle", k), o_idle, vecs[k].e_idle);
      chk($sformatf("v%0d_err", k), o_err, vecs[k].e_err);
    end
    do_reset();

    // Exhaust all tags, then free tag 7 and see it reused.
    for (int i = 0; i < NT; i++) begin
      req(i);
      #1 chk("full_req_r", bus.i_req_r, 1);
      tick();
      chk("full_tag", bus.o_cmd_tag, i);
      chk("full_sid", bus.o_cmd_sid, i);
    end
    req(40);
    for (int i = 0; i < 3; i++) begin
      #1 chk("full_stall", bus.i_req_r, 0);
      tick();
    end
    bus.i_hrsp_v = 1; bus.i_hrsp_tag = TW'(7);
    #1 chk("free_same_cycle", bus.i_req_r, 0);
    tick();
    bus.i_hrsp_v = 0;
    chk("free7_rsp_v", bus.o_rsp_v, 1);
    chk("free7_rsp_sid", bus.o_rsp_sid, 7);
    #1 chk("free7_req_r", bus.i_req_r, 1);
    tick();
    bus.i_req_v = 0;
    chk("reuse_tag", bus.o_cmd_tag, 7);
    chk("reuse_sid", bus.o_cmd_sid, 40);
    do_reset();

    // Per-stream limit stalls only that stream.
    for (int i = 0; i < MO; i++) begin req(3); tick(); end
    req(3);
    #1 chk("sid3_stall", bus.i_req_r, 0);
    req(4);
    #1 chk("sid4_go", bus.i_req_r, 1);
    tick();
    bus.i_req_v = 0;
    chk("sid4_tag", bus.o_cmd_tag, MO);
    chk("sid4_sid", bus.o_cmd_sid, 4);
    do_reset();

    // Out-of-order completion and response back-pressure.
    for (int i = 0; i < 4; i++) begin req(10 + i); tick(); end
    bus.i_req_v = 0; tick();
    bus.i_hrsp_v = 1;
    bus.i_hrsp_tag = TW'(2); tick(); chk("ooo0_sid", bus.o_rsp_sid, 12);
    bus.i_hrsp_tag = TW'(0); tick(); chk("ooo1_sid", bus.o_rsp_sid, 10);
    bus.i_hrsp_tag = TW'(1); tick(); chk("ooo2_sid", bus.o_rsp_sid, 11);
    bus.o_rsp_r = 0; bus.i_hrsp_tag = TW'(3);
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_hrsp_r", bus.i_hrsp_r, 0);
      chk("bp_rsp_v", bus.o_rsp_v, 1);
      chk("bp_rsp_sid", bus.o_rsp_sid, 11);
      tick();
    end
    bus.o_rsp_r = 1;
    #1 chk("bp_release", bus.i_hrsp_r, 1);
    tick();
    bus.i_hrsp_v = 0;
    chk("bp_last_sid", bus.o_rsp_sid, 13);
    tick();
    chk("bp_idle", o_idle, 1);
    do_reset();

    // 10 issued commands then 4 stall cycles behind a held command.
    for (int i = 0; i < 10; i++) begin req(i); tick(); end
    bus.i_req_v = 0; tick();
    req(20); bus.o_cmd_r = 0; tick();
    req(21);
    for (int i = 0; i < 4; i++) tick();
    bus.i_req_v = 0; tick();
    chk("perf_req", o_perf_req, PERF ? 10 : 0);
    chk("perf_stall", o_perf_stall, PERF ? 4 : 0);
    do_reset();

    // Random traffic checked cycle by cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      int nb, pick;
      reset = ($urandom_range(0, 599) != 0);
      bus.i_req_v = ($urandom_range(0, 3) != 0);
      bus.i_req_sid = SW'($urandom_range(0, 7));
      bus.o_cmd_r = ($urandom_range(0, 3) != 0);
      bus.o_rsp_r = ($urandom_range(0, 3) != 0);
      nb = 0;
      foreach (m_busy[i]) if (m_busy[i]) nb++;
      bus.i_hrsp_v = 0;
      if ($urandom_range(0, 99) == 0) begin
        bus.i_hrsp_v = 1; bus.i_hrsp_tag = TW'($urandom_range(0, NT - 1));
      end else if (nb > 0 && $urandom_range(0, 1) == 1) begin
        pick = $urandom_range(0, nb - 1);
        foreach (m_busy[i]) begin
          if (m_busy[i]) begin
            if (pick == 0) begin bus.i_hrsp_v = 1; bus.i_hrsp_tag = TW'(i); end
            pick--;
          end
        end
      end
      tick();
    end
    reset = 1;
    set_idle();
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
